// File: rtl/byte_serial_addsub_if.sv
// Request/response bundle for byte_serial_addsub: operand request on the
// in_* handshake, result and flags on the out_* handshake.
interface byte_serial_addsub_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        busy;

  modport master (
    output in_valid, data_operandA, data_operandB, op_sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, op_sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/byte_serial_addsub.sv
// 32-bit add/subtract computed over four cycles on one 8-bit lookahead slice,
// LSB first. Subtract support compiled in only with BYTE_SERIAL_ADDSUB_SUB_EN.
module byte_serial_addsub (
  input  logic                  clock,
  input  logic                  reset,
  byte_serial_addsub_if.slave   bus,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE, out_valid only in DONE; the
  // result and flags are held unchanged while out_valid waits for out_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        c;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] result_r;
  logic        carry_out_r;
  logic        overflow_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;

  logic [7:0]  slice_a;
  logic [7:0]  slice_b;
  logic [7:0]  slice_sum;
  logic [8:0]  slice_c;

  assign slice_a = a_r[8*idx +: 8];
  assign slice_b = b_r[8*idx +: 8];

  // Each carry is built straight from the byte's generate/propagate terms and
  // the incoming carry, so no carry chain runs bit to bit.
  always_comb begin
    logic [7:0] g;
    logic [7:0] p;
    logic       acc;
    logic       pp;
    g          = slice_a & slice_b;
    p          = slice_a ^ slice_b;
    slice_c    = '0;
    slice_c[0] = c;
    acc        = 1'b0;
    pp         = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      slice_c[i+1] = acc | (pp & c);
    end
    slice_sum = p ^ slice_c[7:0];
  end

`ifdef BYTE_SERIAL_ADDSUB_SUB_EN
  logic [31:0] b_load;
  logic        c_load;
  assign b_load = bus.op_sub ? ~bus.data_operandB : bus.data_operandB;
  assign c_load = bus.op_sub;
`else
  logic [31:0] b_load;
  logic        c_load;
  logic        unused_op_sub;
  assign b_load        = bus.data_operandB;
  assign c_load        = 1'b0;
  assign unused_op_sub = bus.op_sub;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 2'd0;
      c           <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.data_operandA;
            b_r        <= b_load;
            c          <= c_load;
            idx        <= 2'd0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          result_r[8*idx +: 8] <= slice_sum;
          c                    <= slice_c[8];
          idx                  <= idx + 2'd1;
          if (idx == 2'd3) begin
            // b_r already holds the inverted operand for a subtract
            carry_out_r <= slice_c[8];
            overflow_r  <= (a_r[31] == b_r[31]) & (slice_sum[7] != a_r[31]);
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign state_dbg     = state;

endmodule
